parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, number of data bits per frame (2..32).
REQ-002 SHALL provide parameter ODD_PARITY, default 0; 0 = even parity expected, 1 = odd parity expected, over data bits plus parity bit.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bit_in  input  1  serial data or parity bit, sampled only when bit_valid=1.
REQ-007 bit_valid  input  1  qualifies bit_in for the current cycle.
REQ-008 clear_err  input  1  one-cycle request to zero err_count.
REQ-009 data_out  output  DATA_W  last completed frame data; MSB received first.
REQ-010 data_valid  output  1  one-cycle pulse, frame complete.
REQ-011 parity_err  output  1  parity result of last frame, valid with and held after data_valid.
REQ-012 err_count  output  8  saturating count of frames with parity error.
REQ-013 busy  output  1  high while a frame is partially received.

Function
REQ-014 Frame SHALL be DATA_W data bits, MSB first, then one parity bit; no start/stop bits.
REQ-015 FSM SHALL have states IDLE, DATA, PARITY.
REQ-016 IDLE: bit_valid=1 -> shift bit_in into shift register, bit count=1, running parity=bit_in, go DATA (or PARITY when DATA_W=1 is not supported; DATA_W>=2).
REQ-017 DATA: each bit_valid=1 shifts bit_in in at LSB, increments count, XORs running parity; on the DATA_W-th bit -> PARITY.
REQ-018 PARITY: bit_valid=1 -> go IDLE; same edge registers data_out=shift register, parity_err=(running parity XOR bit_in) != ODD_PARITY, data_valid=1.
REQ-019 Latency SHALL be one cycle: data_valid high in the cycle after the parity bit is sampled.
REQ-020 bit_valid=0 in any state SHALL hold state, count, shift register and running parity; gaps of any length allowed.
REQ-021 data_valid SHALL be high exactly one cycle per frame; data_out and parity_err SHALL hold until the next frame completes.
REQ-022 A bit_valid in the cycle data_valid is high SHALL be accepted as the first bit of the next frame (back-to-back frames, no dead cycle).
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 err_count SHALL increment by 1 on each frame with parity_err=1, saturating at 255 (no wrap).
REQ-025 clear_err alone SHALL set err_count=0 next cycle; clear_err together with an error frame completion SHALL set err_count=1.
REQ-026 Partial frames SHALL never produce data_valid.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, count 0, running parity 0, shift register 0.
REQ-028 Reset values: data_out=0, data_valid=0, parity_err=0, err_count=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; next bit_valid after rst deasserts starts a new frame.

Verification
REQ-030 Even mode, bits 0111_0001 then parity 0, bit_valid continuous -> data_out=0x71, parity_err=0, err_count=0, data_valid one cycle after parity bit.
REQ-031 Even mode, 0101_0001 parity 0, then back-to-back 1111_1111 parity 0 -> first frame parity_err=1, err_count=1; second data_out=0xFF, parity_err=0, err_count=1, no idle cycle between frames.
REQ-032 ODD_PARITY=1, 0111_1111 parity 0 with bit_valid low every other cycle -> data_out=0x7F, parity_err=0, busy high throughout frame.
REQ-033 256 consecutive error frames -> err_count=255 held; then clear_err coincident with error frame -> err_count=1; clear_err alone -> 0.
REQ-034 rst asserted after 5 data bits, then full frame 0x71 parity 0 -> no data_valid for partial frame; data_out=0x71, parity_err=0 for the new frame.

Source files
------------

// File: rtl/parity_rx.sv
// -----------------------------------------------------------------------------
// parity_rx -- serial frame receiver with parity check.
//
// A frame is DATA_W data bits (MSB first) followed by one parity bit. There are
// no start/stop bits; framing comes only from counting qualified bits.
// Parity is checked over the data bits plus the parity bit. ODD_PARITY=0 means
// an even total is expected, and ODD_PARITY=1 means an odd total is expected.
//
// Handshake: bit_in is consumed on every rising edge where bit_valid=1. There is
// no back-pressure. bit_valid=0 freezes all frame state for any number of cycles.
// data_valid is a one-cycle pulse in the cycle after the parity bit is sampled.
// A bit offered during that pulse starts the next frame.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bit_in      serial data / parity bit
//   bit_valid   qualifies bit_in
//   clear_err   one-cycle request to zero err_count
//   data_out    data of the last completed frame (held)
//   data_valid  one-cycle frame-complete pulse
//   parity_err  parity result of the last frame (held)
//   err_count   saturating count of frames with a parity error
//   busy        high while a frame is partially received
//   dbg_state   current FSM state (0=IDLE, 1=DATA, 2=PARITY)
// -----------------------------------------------------------------------------
module parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               parity_err_q, parity_err_d;
    logic [7:0]         err_count_q, err_count_d;

    logic               par_fail;
    logic               err_done;

    // Total parity over the data bits plus the parity bit, compared with the expected sense.
    assign par_fail = ((par_q ^ bit_in) != ODD_PARITY);
    assign err_done = (state_q == PARITY) && bit_valid && par_fail;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    shift_d = {shift_q[DATA_W-2:0], bit_in};
                    cnt_d   = CNT_W'(1);
                    par_d   = bit_in;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    shift_d = {shift_q[DATA_W-2:0], bit_in};
                    cnt_d   = cnt_q + CNT_W'(1);
                    par_d   = par_q ^ bit_in;
                    // This bit is the DATA_W-th one when the count is DATA_W-1 before it.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    par_d        = 1'b0;
                    data_out_d   = shift_q;
                    parity_err_d = par_fail;
                    data_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear that coincides with an error frame leaves a count of one.
        if (clear_err) begin
            err_count_d = err_done ? 8'd1 : 8'd0;
        end else if (err_done && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_rx -- bench for parity_rx.
// Two instances share the same input stream: one expects even parity and the
// other expects odd parity. The reference model works per frame. It counts the
// ones in each frame and keeps the expected held outputs and error counters.
// -----------------------------------------------------------------------------
module tb_parity_rx;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          bit_in;
    logic          bit_valid;
    logic          clear_err;

    logic [DW-1:0] data_out_ev, data_out_od;
    logic          data_valid_ev, data_valid_od;
    logic          parity_err_ev, parity_err_od;
    logic [7:0]    err_count_ev, err_count_od;
    logic          busy_ev, busy_od;
    logic [1:0]    dbg_state_ev, dbg_state_od;

    int n_cmp;
    int n_bad;

    // Expected held outputs and counters.
    logic [DW-1:0] m_data;
    logic          m_perr_ev, m_perr_od;
    int            m_err_ev, m_err_od;
    int            m_frames;
    int            pulses_ev, pulses_od;

    parity_rx #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut_ev (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear_err  (clear_err),
        .data_out   (data_out_ev),
        .data_valid (data_valid_ev),
        .parity_err (parity_err_ev),
        .err_count  (err_count_ev),
        .busy       (busy_ev),
        .dbg_state  (dbg_state_ev)
    );

    parity_rx #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_od (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear_err  (clear_err),
        .data_out   (data_out_od),
        .data_valid (data_valid_od),
        .parity_err (parity_err_od),
        .err_count  (err_count_od),
        .busy       (busy_od),
        .dbg_state  (dbg_state_od)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count data_valid cycles away from the active edge. A pulse that is too long shows up as extra counts.
    initial begin
        pulses_ev = 0;
        pulses_od = 0;
    end
    always @(negedge clk) begin
        if (data_valid_ev === 1'b1) pulses_ev++;
        if (data_valid_od === 1'b1) pulses_od++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs. The outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic b, input logic v, input logic clr);
        bit_in    = b;
        bit_valid = v;
        clear_err = clr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        clear_err = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
    endtask

    task automatic check_held();
        check("data_out_ev", 32'(data_out_ev), 32'(m_data));
        check("data_out_od", 32'(data_out_od), 32'(m_data));
        check("perr_ev", 32'(parity_err_ev), 32'(m_perr_ev));
        check("perr_od", 32'(parity_err_od), 32'(m_perr_od));
        check("errcnt_ev", 32'(err_count_ev), 32'(m_err_ev));
        check("errcnt_od", 32'(err_count_od), 32'(m_err_od));
    endtask

    // Idle cycles with junk on bit_in. Frame state must not move and outputs must hold.
    task automatic gap_cycles(input int n, input logic in_frame);
        for (int k = 0; k < n; k++) begin
            drive(1'($urandom_range(1, 0)), 1'b0, 1'b0);
            check("gap_busy_ev", 32'(busy_ev), 32'(in_frame));
            check("gap_busy_od", 32'(busy_od), 32'(in_frame));
            check("gap_dv_ev", 32'(data_valid_ev), 32'd0);
            check("gap_dv_od", 32'(data_valid_od), 32'd0);
            check("gap_dout_ev", 32'(data_out_ev), 32'(m_data));
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        m_data    = '0;
        m_perr_ev = 1'b0;
        m_perr_od = 1'b0;
        m_err_ev  = 0;
        m_err_od  = 0;
    endtask

    task automatic model_err(inout int cnt, input logic perr, input logic clr);
        if (clr) cnt = perr ? 1 : 0;
        else if (perr && cnt < 255) cnt = cnt + 1;
    endtask

    // Send one full frame with random gaps between bits, then check the completion cycle.
    task automatic send_frame(input logic [DW-1:0] data, input logic pbit,
                              input int gmin, input int gmax, input logic clr);
        int ones;
        for (int i = DW - 1; i >= 0; i--) begin
            gap_cycles($urandom_range(gmax, gmin), (i != DW - 1));
            drive(data[i], 1'b1, 1'b0);
            check("bit_busy_ev", 32'(busy_ev), 32'd1);
            check("bit_busy_od", 32'(busy_od), 32'd1);
            check("bit_dv_ev", 32'(data_valid_ev), 32'd0);
        end
        gap_cycles($urandom_range(gmax, gmin), 1'b1);
        drive(pbit, 1'b1, clr);
        ones      = $countones(data) + int'(pbit);
        m_data    = data;
        m_perr_ev = (ones % 2) != 0;
        m_perr_od = (ones % 2) != 1;
        model_err(m_err_ev, m_perr_ev, clr);
        model_err(m_err_od, m_perr_od, clr);
        m_frames++;
        check("done_dv_ev", 32'(data_valid_ev), 32'd1);
        check("done_dv_od", 32'(data_valid_od), 32'd1);
        check("done_busy_ev", 32'(busy_ev), 32'd0);
        check_held();
    endtask

    task automatic clear_alone();
        drive(1'b0, 1'b0, 1'b1);
        m_err_ev = 0;
        m_err_od = 0;
        check_held();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        m_frames  = 0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear_err = 1'b0;
        rst       = 1'b0;

        // Reset values.
        apply_reset(3);
        check("rst_dv_ev", 32'(data_valid_ev), 32'd0);
        check("rst_busy_ev", 32'(busy_ev), 32'd0);
        check("rst_busy_od", 32'(busy_od), 32'd0);
        check_held();

        // Continuous frame 0x71 with parity bit 0.
        send_frame(8'h71, 1'b0, 0, 0, 1'b0);
        check("v030_perr", 32'(parity_err_ev), 32'd0);

        // Error frame followed back-to-back by a good frame.
        send_frame(8'h51, 1'b0, 0, 0, 1'b0);
        check("v031_err1", 32'(err_count_ev), 32'd1);
        send_frame(8'hFF, 1'b0, 0, 0, 1'b0);
        check("v031_err2", 32'(err_count_ev), 32'd1);
        check("v031_data", 32'(data_out_ev), 32'hFF);

        // bit_valid low every other cycle. The odd-parity instance sees a good frame.
        send_frame(8'h7F, 1'b0, 1, 1, 1'b0);
        check("v032_perr_od", 32'(parity_err_od), 32'd0);

        // Reset after 5 data bits discards the partial frame.
        for (int i = DW - 1; i >= DW - 5; i--) drive(i[0], 1'b1, 1'b0);
        apply_reset(1);
        check("v034_busy", 32'(busy_ev), 32'd0);
        check_held();
        gap_cycles(2, 1'b0);
        send_frame(8'h71, 1'b0, 0, 2, 1'b0);
        check("v034_data", 32'(data_out_ev), 32'h71);

        // Random frames, gaps, parity bits and occasional clears.
        for (int f = 0; f < 40; f++) begin
            send_frame(8'($urandom), 1'($urandom_range(1, 0)), 0, 3,
                       ($urandom_range(7, 0) == 0));
            if ($urandom_range(9, 0) == 0) clear_alone();
        end

        // Saturation: 0x01 with parity 0 is an error for even mode only.
        clear_alone();
        for (int f = 0; f < 257; f++) send_frame(8'h01, 1'b0, 0, 0, 1'b0);
        check("sat_ev", 32'(err_count_ev), 32'd255);
        send_frame(8'h01, 1'b0, 0, 1, 1'b1);
        check("sat_clr_err", 32'(err_count_ev), 32'd1);
        clear_alone();
        check("sat_clr_alone", 32'(err_count_ev), 32'd0);

        gap_cycles(3, 1'b0);
        check("pulses_ev", 32'(pulses_ev), 32'(m_frames));
        check("pulses_od", 32'(pulses_od), 32'(m_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
